uart_mem_arbiter: RTL and testbench
===================================

# uart_mem_arbiter

Two-port arbiter that shares the single-port 2 KiB byte RAM between the CPU load/store path (port A) and the UART bridge (port B). It accepts one access per cycle on the RAM side, grants requesters round-robin or by fixed priority, registers every RAM control signal, and returns read data with a fixed latency. It sits between the requesters and the RAM macro. The UART bridge reaches the RAM only through this block.

## Interface
Parameters:
- AW, 11: byte address width (2 KiB RAM).
- DW, 8: data width.
- FIXED_PRI, 0: 0 selects round-robin; 1 selects fixed priority with port A always winning.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_req, b_req  in  1  access request; held high until the matching gnt is seen.
- a_we, b_we  in  1  1 = write, 0 = read; stable while req is high.
- a_ad, b_ad  in  AW  byte address; stable while req is high.
- a_wd, b_wd  in  DW  write data; stable while req is high.
- a_gnt, b_gnt  out  1  one-cycle grant pulse; the request was issued to RAM.
- a_rd, b_rd  out  DW  read data; valid when the matching rvalid is high, holds otherwise.
- a_rvalid, b_rvalid  out  1  one-cycle pulse, two cycles after a read grant.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_ad  out  AW  RAM address.
- mem_wd  out  DW  RAM write data.
- mem_rd  in  DW  RAM read data; synchronous RAM, valid the cycle after mem_en is sampled.

## Operation
- Reset (rst_n low, asynchronous) clears every output and all state:
  - gnt, rvalid and mem_en are 0; all other outputs are 0.
  - last_gnt is set to B, so A wins the first tie.
  - In-flight reads are dropped and no rvalid is produced after reset releases.
- Eligibility:
  - A port is eligible at edge E if its req is high and it was not granted at edge E-1.
  - The grant mask absorbs the requester's one-cycle gnt-to-deassert reaction.
  - Each port therefore receives at most one grant per 2 cycles.
- Pick:
  - With one eligible port, that port wins.
  - With two eligible ports and FIXED_PRI=0, the port not equal to last_gnt wins; last_gnt then updates to the winner.
  - With two eligible ports and FIXED_PRI=1, A always wins.
  - With no eligible port, mem_en=0 and the other mem outputs hold their values.
- Issue at edge E:
  - mem_en, mem_we, mem_ad and mem_wd are registered from the winner.
  - The winner's gnt is high for the cycle after E.
- Read tracking:
  - A 2-stage shift register tags each issued read with its port ID.
  - At E+2 the block captures mem_rd into that port's rd register and pulses that port's rvalid.
  - Writes produce no rvalid.
- Back-to-back accesses alternate A,B,A,B... when both ports hold req; RAM utilisation is 100%.
- Read after write to the same address from either port returns the new data, because RAM accesses are issued in grant order.

## Timing
- Request to grant: req sampled at E0; gnt and mem_en are high during cycle E0→E1.
- RAM sampling: the RAM samples at E1; mem_rd is valid in E1→E2.
- Read completion: rd and rvalid are valid in E2→E3, so rvalid rises 2 cycles after gnt.
- Requesters must drop req (or present the next access) at the edge that ends their gnt cycle.
- Simultaneous rvalid on A and B is impossible, because only one read is issued per cycle.
- No combinational path exists from any req/we/ad/wd input to any output.

## Structure
- Shared package uart_mem_pkg holds:
  - AW/DW defaults.
  - Port-ID constants PORT_A=1'b0 and PORT_B=1'b1.
  - The read-tag record type {valid, port}.
- Sub-module rr_arb2 contains:
  - the 2-input pick with mask and last_gnt register;
  - FIXED_PRI passed through as a parameter.
- The top level holds the issue registers, the read-tag pipeline and the rd/rvalid demux.

## Test plan
- Reset release with a_req=b_req=0:
  - All outputs stay 0 for 10 cycles.
- A write then read:
  - Stimulus: a_req/a_we=1, a_ad=0x123, a_wd=0x5A; then a read of 0x123.
  - Required: a_gnt is high for 1 cycle, then a second a_gnt; a_rvalid rises 2 cycles after the read gnt with a_rd=0x5A.
- Contention, FIXED_PRI=0, a_req and b_req both held for 8 cycles:
  - Required: gnt sequence A,B,A,B...
  - Required: mem_en is high every cycle after the first.
  - Required: each rvalid lands on the correct port, with B reads of its preloaded 0xC3 never seen on A.
- Contention, FIXED_PRI=1:
  - Required: A is granted every other cycle; B fills only the masked A cycles.
- Reset mid-read:
  - Stimulus: assert rst_n=0 in the cycle after b_gnt for a read.
  - Required: b_rvalid never pulses; mem_en=0 immediately.
- Single requester, B holding req continuously:
  - Required: b_gnt pulses every 2nd cycle.
  - Required: mem_en is 0 on the alternate cycles.

Source files
------------

// File: rtl/uart_mem_arbiter_pkg.sv
// Shared types and constants for the UART/CPU RAM arbiter: default widths,
// requester port IDs and the read-tag record carried down the return pipeline.
package uart_mem_pkg;

    localparam int unsigned AW_DEFAULT = 11;
    localparam int unsigned DW_DEFAULT = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/uart_mem_arbiter_if.sv
// Bundle of the two requester ports and the RAM macro port seen by the arbiter.
// slave = arbiter side, master = requesters plus RAM macro side.
interface uart_mem_arbiter_if
    import uart_mem_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_ad;
    logic [DW-1:0] a_wd;
    logic          a_gnt;
    logic [DW-1:0] a_rd;
    logic          a_rvalid;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_ad;
    logic [DW-1:0] b_wd;
    logic          b_gnt;
    logic [DW-1:0] b_rd;
    logic          b_rvalid;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_ad;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  a_req, a_we, a_ad, a_wd,
        input  b_req, b_we, b_ad, b_wd,
        input  mem_rd,
        output a_gnt, a_rd, a_rvalid,
        output b_gnt, b_rd, b_rvalid,
        output mem_en, mem_we, mem_ad, mem_wd
    );

    modport master (
        output a_req, a_we, a_ad, a_wd,
        output b_req, b_we, b_ad, b_wd,
        output mem_rd,
        input  a_gnt, a_rd, a_rvalid,
        input  b_gnt, b_rd, b_rvalid,
        input  mem_en, mem_we, mem_ad, mem_wd
    );

endinterface

// File: rtl/uart_mem_arbiter_arb.sv
// rr_arb2: two-input pick with a one-cycle post-grant mask and a last-grant
// pointer; FIXED_PRI=1 makes port A win every tie.
module rr_arb2
    import uart_mem_pkg::*;
#(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic pick_vld_o,
    output logic pick_port_o,
    output logic a_gnt_o,
    output logic b_gnt_o
);

    logic a_gnt_q, a_gnt_d;
    logic b_gnt_q, b_gnt_d;
    logic last_q, last_d;
    logic a_elig, b_elig;

    // A port granted last cycle is masked while its requester reacts to gnt.
    assign a_elig = a_req_i & ~a_gnt_q;
    assign b_elig = b_req_i & ~b_gnt_q;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        pick_vld_o  = a_elig | b_elig;
        pick_port_o = PORT_A;
        if (a_elig && b_elig) begin
            if (FIXED_PRI) pick_port_o = PORT_A;
            else           pick_port_o = (last_q == PORT_A) ? PORT_B : PORT_A;
        end else if (b_elig) begin
            pick_port_o = PORT_B;
        end
        last_d  = pick_vld_o ? pick_port_o : last_q;
        a_gnt_d = pick_vld_o && (pick_port_o == PORT_A);
        b_gnt_d = pick_vld_o && (pick_port_o == PORT_B);
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            last_q  <= PORT_B;
        end else begin
            a_gnt_q <= a_gnt_d;
            b_gnt_q <= b_gnt_d;
            last_q  <= last_d;
        end
    end

    assign a_gnt_o = a_gnt_q;
    assign b_gnt_o = b_gnt_q;

endmodule

// File: rtl/uart_mem_arbiter.sv
// Shares one synchronous single-port RAM between the CPU (A) and UART bridge (B):
// registered issue stage, 2-deep read-tag pipeline and per-port read-data return.
module uart_mem_arbiter
    import uart_mem_pkg::*;
#(
    parameter int unsigned AW        = AW_DEFAULT,
    parameter int unsigned DW        = DW_DEFAULT,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_mem_arbiter_if.slave   bus
);

    logic          pick_vld, pick_port;
    logic          a_gnt, b_gnt;

    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_ad_q, mem_ad_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;

    rd_tag_t       tag0_q, tag0_d, tag1_q;

    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rd_q, a_rd_d;
    logic [DW-1:0] b_rd_q, b_rd_d;

    rr_arb2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_req_i     (bus.a_req),
        .b_req_i     (bus.b_req),
        .pick_vld_o  (pick_vld),
        .pick_port_o (pick_port),
        .a_gnt_o     (a_gnt),
        .b_gnt_o     (b_gnt)
    );

    always_comb begin
        mem_en_d = pick_vld;
        mem_we_d = mem_we_q;
        mem_ad_d = mem_ad_q;
        mem_wd_d = mem_wd_q;
        if (pick_vld) begin
            if (pick_port == PORT_A) begin
                mem_we_d = bus.a_we;
                mem_ad_d = bus.a_ad;
                mem_wd_d = bus.a_wd;
            end else begin
                mem_we_d = bus.b_we;
                mem_ad_d = bus.b_ad;
                mem_wd_d = bus.b_wd;
            end
        end

        // Only reads are tagged; the tag reaches the return stage as mem_rd becomes valid.
        tag0_d.valid = pick_vld & ~mem_we_d;
        tag0_d.port  = pick_port;

        a_rvalid_d = tag1_q.valid && (tag1_q.port == PORT_A);
        b_rvalid_d = tag1_q.valid && (tag1_q.port == PORT_B);
        a_rd_d     = a_rvalid_d ? bus.mem_rd : a_rd_q;
        b_rd_d     = b_rvalid_d ? bus.mem_rd : b_rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_ad_q   <= '0;
            mem_wd_q   <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rd_q     <= '0;
            b_rd_q     <= '0;
        end else begin
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_ad_q   <= mem_ad_d;
            mem_wd_q   <= mem_wd_d;
            tag0_q     <= tag0_d;
            tag1_q     <= tag0_q;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rd_q     <= a_rd_d;
            b_rd_q     <= b_rd_d;
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rd     = a_rd_q;
    assign bus.b_rd     = b_rd_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_ad   = mem_ad_q;
    assign bus.mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Bench for uart_mem_arbiter: a round-robin and a fixed-priority instance, each with a
// RAM model, per-port requester drivers, and a reference memory feeding read scoreboards.
module tb_uart_mem_arbiter;
    import uart_mem_pkg::*;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int NK = 4;  // index k = dut*2 + port; dut 0 round-robin, dut 1 fixed priority

    typedef struct {
        bit            we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
    } op_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_mem_arbiter_if #(.AW(AW), .DW(DW)) bus_rr ();
    uart_mem_arbiter_if #(.AW(AW), .DW(DW)) bus_fp ();

    uart_mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));
    uart_mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus_fp.slave));

    logic          req    [NK];
    logic          we     [NK];
    logic [AW-1:0] ad     [NK];
    logic [DW-1:0] wd     [NK];
    logic          gnt    [NK];
    logic          rvalid [NK];
    logic [DW-1:0] rd     [NK];

    assign bus_rr.a_req = req[0]; assign bus_rr.a_we = we[0]; assign bus_rr.a_ad = ad[0]; assign bus_rr.a_wd = wd[0];
    assign bus_rr.b_req = req[1]; assign bus_rr.b_we = we[1]; assign bus_rr.b_ad = ad[1]; assign bus_rr.b_wd = wd[1];
    assign bus_fp.a_req = req[2]; assign bus_fp.a_we = we[2]; assign bus_fp.a_ad = ad[2]; assign bus_fp.a_wd = wd[2];
    assign bus_fp.b_req = req[3]; assign bus_fp.b_we = we[3]; assign bus_fp.b_ad = ad[3]; assign bus_fp.b_wd = wd[3];

    assign gnt[0] = bus_rr.a_gnt; assign rvalid[0] = bus_rr.a_rvalid; assign rd[0] = bus_rr.a_rd;
    assign gnt[1] = bus_rr.b_gnt; assign rvalid[1] = bus_rr.b_rvalid; assign rd[1] = bus_rr.b_rd;
    assign gnt[2] = bus_fp.a_gnt; assign rvalid[2] = bus_fp.a_rvalid; assign rd[2] = bus_fp.a_rd;
    assign gnt[3] = bus_fp.b_gnt; assign rvalid[3] = bus_fp.b_rvalid; assign rd[3] = bus_fp.b_rd;

    // Initial RAM contents: the UART area from 0x200 up holds 0xC3, CPU area holds values below 0x80.
    function automatic logic [DW-1:0] preload(input int i);
        return (i >= 'h200) ? 8'hC3 : 8'(i & 'h7F);
    endfunction

    logic [DW-1:0] ram [2][2048];

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ram[0][i] = preload(i);
            ram[1][i] = preload(i);
        end
        forever begin
            @(posedge clk);
            if (bus_rr.mem_en) begin
                if (bus_rr.mem_we) ram[0][bus_rr.mem_ad] = bus_rr.mem_wd;
                else               bus_rr.mem_rd <= ram[0][bus_rr.mem_ad];
            end
            if (bus_fp.mem_en) begin
                if (bus_fp.mem_we) ram[1][bus_fp.mem_ad] = bus_fp.mem_wd;
                else               bus_fp.mem_rd <= ram[1][bus_fp.mem_ad];
            end
        end
    end

    op_t           op_q   [NK][$];
    logic [DW-1:0] exp_q  [NK][$];
    int            t_q    [NK][$];
    int            gl     [2][$];   // per-cycle grant log: 0 = A, 1 = B, 2 = none
    bit            el     [2][$];   // per-cycle mem_en log
    logic [DW-1:0] ref_mem [2][2048];
    int            gcnt   [NK];
    int            rv_cnt [NK];
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;

    // Requester drivers plus read scoreboard; reference memory is updated in grant order.
    initial begin
        op_t           o;
        int            d;
        int            t;
        logic [DW-1:0] e;
        for (int i = 0; i < 2048; i++) begin
            ref_mem[0][i] = preload(i);
            ref_mem[1][i] = preload(i);
        end
        for (int k = 0; k < NK; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; ad[k] = '0; wd[k] = '0;
            gcnt[k] = 0; rv_cnt[k] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                for (int k = 0; k < NK; k++) begin
                    req[k] = 1'b0;
                    op_q[k].delete();
                    exp_q[k].delete();
                    t_q[k].delete();
                end
            end else begin
                gl[0].push_back(gnt[0] ? 0 : (gnt[1] ? 1 : 2));
                gl[1].push_back(gnt[2] ? 0 : (gnt[3] ? 1 : 2));
                el[0].push_back(bus_rr.mem_en);
                el[1].push_back(bus_fp.mem_en);
                for (int k = 0; k < NK; k++) begin
                    d = k / 2;
                    if (rvalid[k]) begin
                        rv_cnt[k]++;
                        checks++;
                        if (exp_q[k].size() == 0) begin
                            errors++;
                            $display("FAIL rvalid_unexpected k=%0d rd=%h, no read outstanding", k, rd[k]);
                        end else begin
                            e = exp_q[k].pop_front();
                            t = t_q[k].pop_front();
                            if (rd[k] !== e) begin
                                errors++;
                                $display("FAIL rd_data k=%0d got %h expected %h", k, rd[k], e);
                            end
                            checks++;
                            if (cyc - t != 2) begin
                                errors++;
                                $display("FAIL rvalid_latency k=%0d got %0d cycles expected 2", k, cyc - t);
                            end
                        end
                    end
                    if (gnt[k]) begin
                        checks++;
                        if (req[k] !== 1'b1) begin
                            errors++;
                            $display("FAIL gnt_without_req k=%0d req=%b expected 1", k, req[k]);
                        end
                        if (we[k]) ref_mem[d][ad[k]] = wd[k];
                        else begin
                            exp_q[k].push_back(ref_mem[d][ad[k]]);
                            t_q[k].push_back(cyc);
                        end
                        gcnt[k]++;
                        req[k] = 1'b0;
                    end
                    if (!req[k] && op_q[k].size() > 0) begin
                        o = op_q[k].pop_front();
                        req[k] = 1'b1; we[k] = o.we; ad[k] = o.ad; wd[k] = o.wd;
                    end
                end
            end
        end
    end

    function automatic void push_op(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] v);
        op_q[k].push_back('{we: w, ad: a, wd: v});
    endfunction

    function automatic bit busy();
        for (int k = 0; k < NK; k++)
            if (req[k] || op_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int first_grant(input int d);
        for (int i = 0; i < gl[d].size(); i++)
            if (gl[d][i] != 2) return i;
        return -1;
    endfunction

    function automatic logic [40:0] outs(input int d);
        if (d == 0)
            return {bus_rr.a_gnt, bus_rr.b_gnt, bus_rr.a_rvalid, bus_rr.b_rvalid, bus_rr.mem_en,
                    bus_rr.mem_we, bus_rr.mem_ad, bus_rr.mem_wd, bus_rr.a_rd, bus_rr.b_rd};
        return {bus_fp.a_gnt, bus_fp.b_gnt, bus_fp.a_rvalid, bus_fp.b_rvalid, bus_fp.mem_en,
                bus_fp.mem_we, bus_fp.mem_ad, bus_fp.mem_wd, bus_fp.a_rd, bus_fp.b_rd};
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy() && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (busy()) begin
            errors++;
            $display("FAIL %s_timeout still busy after %0d cycles, expected idle", name, budget);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        gl[0].delete(); gl[1].delete();
        el[0].delete(); el[1].delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (outs(d) !== '0) begin
                errors++;
                $display("FAIL reset_held dut%0d outputs %h expected 0", d, outs(d));
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (outs(d) !== '0) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d cycle %0d outputs %h expected 0", d, c, outs(d));
                end
            end
        end
    endtask

    task automatic test_write_read();
        int g0, fg;
        do_reset();
        g0 = gcnt[0];
        push_op(0, 1'b1, 11'h123, 8'h5A);
        push_op(0, 1'b0, 11'h123, 8'h00);
        wait_idle(50, "write_read");
        checks++;
        if (gcnt[0] - g0 != 2) begin
            errors++;
            $display("FAIL wr_gnt_count got %0d expected 2", gcnt[0] - g0);
        end
        fg = first_grant(0);
        checks++;
        if (fg < 0 || gl[0].size() < fg + 3 || gl[0][fg] != 0 || gl[0][fg+1] != 2 || gl[0][fg+2] != 0) begin
            errors++;
            $display("FAIL wr_gnt_shape first=%0d expected A,none,A", fg);
        end
        checks++;
        if (bus_rr.a_rd !== 8'h5A) begin
            errors++;
            $display("FAIL wr_rd_hold got %h expected 5a", bus_rr.a_rd);
        end
    endtask

    task automatic test_contention_rr();
        int fg, ra, rb;
        do_reset();
        ra = rv_cnt[0]; rb = rv_cnt[1];
        for (int i = 0; i < 8; i++) begin
            if (i == 3) push_op(0, 1'b1, 11'h0F0, 8'hA5);
            else        push_op(0, 1'b0, 11'(16 + i), 8'h00);
            if (i == 5) push_op(1, 1'b0, 11'h0F0, 8'h00);
            else        push_op(1, 1'b0, 11'(12'h200 + i), 8'h00);
        end
        wait_idle(100, "contention_rr");
        fg = first_grant(0);
        checks++;
        if (fg < 0 || gl[0].size() < fg + 16) begin
            errors++;
            $display("FAIL rr_seq_len first=%0d log=%0d expected 16 grants", fg, gl[0].size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (gl[0][fg+i] != i % 2) begin
                    errors++;
                    $display("FAIL rr_gnt_order slot %0d got %0d expected %0d", i, gl[0][fg+i], i % 2);
                end
                checks++;
                if (el[0][fg+i] !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_mem_en slot %0d got %b expected 1", i, el[0][fg+i]);
                end
            end
        end
        checks++;
        if (rv_cnt[0] - ra != 7 || rv_cnt[1] - rb != 8) begin
            errors++;
            $display("FAIL rr_rvalid_count A=%0d B=%0d expected A=7 B=8", rv_cnt[0] - ra, rv_cnt[1] - rb);
        end
    endtask

    task automatic test_fixed_pri();
        int fg;
        do_reset();
        push_op(2, 1'b1, 11'h040, 8'h99);
        wait_idle(30, "fp_prime");
        gl[1].delete(); el[1].delete();
        for (int i = 0; i < 6; i++) begin
            push_op(2, 1'b0, 11'(12'h040 + i), 8'h00);
            push_op(3, 1'b0, 11'(12'h210 + i), 8'h00);
        end
        wait_idle(80, "fixed_pri");
        fg = first_grant(1);
        checks++;
        if (fg < 0 || gl[1].size() < fg + 12) begin
            errors++;
            $display("FAIL fp_seq_len first=%0d expected 12 grants", fg);
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (gl[1][fg+i] != i % 2 || el[1][fg+i] !== 1'b1) begin
                    errors++;
                    $display("FAIL fp_gnt_order slot %0d got %0d/en=%b expected %0d/en=1",
                             i, gl[1][fg+i], el[1][fg+i], i % 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int n, rvb;
        do_reset();
        push_op(0, 1'b0, 11'h011, 8'h00);
        push_op(0, 1'b0, 11'h012, 8'h00);
        push_op(1, 1'b0, 11'h201, 8'h00);
        n = 0;
        while (bus_rr.b_gnt !== 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (bus_rr.b_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrd_b_gnt_timeout b_gnt=%b expected 1", bus_rr.b_gnt);
        end
        @(posedge clk); #2;
        checks++;
        if (bus_rr.mem_en !== 1'b1) begin
            errors++;
            $display("FAIL midrd_pre_mem_en got %b expected 1", bus_rr.mem_en);
        end
        rvb = rv_cnt[1];
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_rr.mem_en !== 1'b0 || bus_rr.b_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrd_async_clear mem_en=%b b_rvalid=%b expected 0/0", bus_rr.mem_en, bus_rr.b_rvalid);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (rv_cnt[1] != rvb) begin
            errors++;
            $display("FAIL midrd_b_rvalid got %0d pulses expected 0", rv_cnt[1] - rvb);
        end
    endtask

    task automatic test_single_b();
        int fg;
        do_reset();
        push_op(1, 1'b1, 11'h300, 8'h77);
        push_op(1, 1'b0, 11'h300, 8'h00);
        push_op(1, 1'b0, 11'h201, 8'h00);
        push_op(1, 1'b1, 11'h201, 8'h1E);
        push_op(1, 1'b0, 11'h201, 8'h00);
        push_op(1, 1'b0, 11'h300, 8'h00);
        wait_idle(60, "single_b");
        fg = first_grant(0);
        checks++;
        if (fg < 0 || gl[0].size() < fg + 11) begin
            errors++;
            $display("FAIL sb_seq_len first=%0d expected 11 slots", fg);
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (gl[0][fg+i] != ((i % 2 == 0) ? 1 : 2) || el[0][fg+i] !== (i % 2 == 0)) begin
                    errors++;
                    $display("FAIL sb_pattern slot %0d got gnt=%0d en=%b expected gnt=%0d en=%b",
                             i, gl[0][fg+i], el[0][fg+i], (i % 2 == 0) ? 1 : 2, i % 2 == 0);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_contention_rr();
        test_fixed_pri();
        test_reset_mid_read();
        test_single_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
